// File: rtl/led_bist_pkg.sv
// Shared state encoding and default parameter values for the LED BIST scheduler.
package led_bist_pkg;

   typedef enum logic [2:0] {
      ST_IDLE   = 3'd0,
      ST_MIRROR = 3'd1,
      ST_FILL   = 3'd2,
      ST_DRAIN  = 3'd3,
      ST_GAP    = 3'd4
   } state_e;

   localparam int unsigned DEF_LED_W      = 4;
   localparam int unsigned DEF_TICK_DIV   = 10;
   localparam int unsigned DEF_DEB_CYCLES = 8;
   localparam int unsigned DEF_CNT_W      = 8;

   function automatic logic is_bist(input state_e s);
      return (s == ST_FILL) || (s == ST_DRAIN) || (s == ST_GAP);
   endfunction

endpackage

// File: rtl/led_bist_scheduler_sw_debounce.sv
// Per-bit stable-count filter: an output bit follows its input only after the
// input has differed from it for DEB_CYCLES consecutive cycles.
module sw_debounce #(
   parameter int unsigned W          = 4,
   parameter int unsigned DEB_CYCLES = 8
) (
   input  logic         clk,
   input  logic         rst,
   input  logic [W-1:0] din,
   output logic [W-1:0] dout
);

   localparam int unsigned CW = $clog2(DEB_CYCLES + 1);

   logic [W-1:0]  out_q, out_d;
   logic [CW-1:0] cnt_q [W];
   logic [CW-1:0] cnt_d [W];

   always_comb begin
      out_d = out_q;
      for (int i = 0; i < int'(W); i++) begin
         cnt_d[i] = cnt_q[i];
         if (din[i] == out_q[i]) begin
            cnt_d[i] = '0;
         end else if (cnt_q[i] == CW'(DEB_CYCLES - 1)) begin
            out_d[i] = din[i];
            cnt_d[i] = '0;
         end else begin
            cnt_d[i] = cnt_q[i] + 1'b1;
         end
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         out_q <= '0;
         for (int i = 0; i < int'(W); i++) cnt_q[i] <= '0;
      end else begin
         out_q <= out_d;
         for (int i = 0; i < int'(W); i++) cnt_q[i] <= cnt_d[i];
      end
   end

   assign dout = out_q;

endmodule

// File: rtl/led_bist_scheduler.sv
// LED bank owner: mirrors synchronised switches or runs a walking fill/drain sweep.
// Define SW_DEBOUNCE_EN to insert the sw_debounce filter after the synchroniser.
module led_bist_scheduler
   import led_bist_pkg::*;
#(
   parameter int unsigned LED_W      = DEF_LED_W,
   parameter int unsigned TICK_DIV   = DEF_TICK_DIV,
   parameter int unsigned DEB_CYCLES = DEF_DEB_CYCLES,
   parameter int unsigned CNT_W      = DEF_CNT_W
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [LED_W-1:0] sw,
   output logic [LED_W-1:0] led,
   output logic             bist_active,
   output logic [CNT_W-1:0] sweep_cnt
);

   localparam int unsigned TW     = $clog2(TICK_DIV);
   localparam int unsigned STEP_W = $clog2(LED_W);

   logic [LED_W-1:0]  sync1_q, sync2_q, sw_q;
   logic [TW-1:0]     tick_cnt_q, tick_cnt_d;
   logic              tick, clr_tick, sw_nz;
   state_e            state_q, state_d;
   logic [LED_W-1:0]  pattern_q, pattern_d;
   logic [STEP_W-1:0] step_q, step_d;
   logic [CNT_W-1:0]  sweep_q, sweep_d;
   logic [LED_W-1:0]  led_q, led_d;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         sync1_q <= '0;
         sync2_q <= '0;
      end else begin
         sync1_q <= sw;
         sync2_q <= sync1_q;
      end
   end

`ifdef SW_DEBOUNCE_EN
   sw_debounce #(
      .W          (LED_W),
      .DEB_CYCLES (DEB_CYCLES)
   ) u_sw_debounce (
      .clk  (clk),
      .rst  (rst),
      .din  (sync2_q),
      .dout (sw_q)
   );
`else
   assign sw_q = sync2_q;
`endif

   assign sw_nz = |sw_q;
   assign tick  = (tick_cnt_q == TW'(TICK_DIV - 1));

   // Cleared on walk (re)start so the first step lands TICK_DIV cycles after entry.
   always_comb begin
      tick_cnt_d = tick ? '0 : tick_cnt_q + 1'b1;
      if (clr_tick) tick_cnt_d = '0;
   end

   always_comb begin
      state_d   = state_q;
      pattern_d = pattern_q;
      step_d    = step_q;
      sweep_d   = sweep_q;
      clr_tick  = 1'b0;
      unique case (state_q)
         ST_IDLE, ST_MIRROR: begin
            if (sw_nz) begin
               state_d = ST_MIRROR;
            end else begin
               state_d   = ST_FILL;
               pattern_d = '0;
               step_d    = '0;
               clr_tick  = 1'b1;
            end
         end
         ST_FILL: begin
            if (tick) begin
               pattern_d = {1'b1, pattern_q[LED_W-1:1]};
               if (step_q == STEP_W'(LED_W - 1)) begin
                  state_d = ST_DRAIN;
                  step_d  = '0;
               end else begin
                  step_d = step_q + 1'b1;
               end
            end
         end
         ST_DRAIN: begin
            if (tick) begin
               pattern_d = {pattern_q[LED_W-2:0], 1'b0};
               if (step_q == STEP_W'(LED_W - 1)) begin
                  state_d = ST_GAP;
                  step_d  = '0;
               end else begin
                  step_d = step_q + 1'b1;
               end
            end
         end
         ST_GAP: begin
            if (tick) begin
               state_d = ST_FILL;
               if (sweep_q != '1) sweep_d = sweep_q + 1'b1;
            end
         end
         default: begin
            state_d   = ST_IDLE;
            pattern_d = '0;
            step_d    = '0;
         end
      endcase
      // A live switch aborts any sweep in progress and wins over a same-cycle tick.
      if (is_bist(state_q) && sw_nz) begin
         state_d   = ST_MIRROR;
         pattern_d = '0;
         step_d    = '0;
         sweep_d   = sweep_q;
      end
   end

   always_comb begin
      led_d = '0;
      if (state_d == ST_MIRROR) led_d = sw_q;
      else if (is_bist(state_d)) led_d = pattern_d;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q    <= ST_IDLE;
         pattern_q  <= '0;
         step_q     <= '0;
         sweep_q    <= '0;
         tick_cnt_q <= '0;
         led_q      <= '0;
      end else begin
         state_q    <= state_d;
         pattern_q  <= pattern_d;
         step_q     <= step_d;
         sweep_q    <= sweep_d;
         tick_cnt_q <= tick_cnt_d;
         led_q      <= led_d;
      end
   end

   assign led         = led_q;
   assign bist_active = is_bist(state_q);
   assign sweep_cnt   = sweep_q;

endmodule
